// File: rtl/dcm_phase_scan.sv
// dcm_phase_scan: sweeps DCM fine phase, finds the widest error-free eye and parks at its centre
module dcm_phase_scan #(
  parameter int MAX_STEPS = 200,
  parameter int SETTLE    = 16,
  parameter int WINDOW    = 256,
  parameter int TIMEOUT   = 4096
) (
  input  logic       cclk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       err_i,
  input  logic       dcm_done_i,
  input  logic       dcm_locked_i,
  output logic       wcmd_o,
  output logic [3:0] cmd_o,
  output logic       busy_o,
  output logic       cal_done_o,
  output logic       cal_fail_o,
  output logic [8:0] eye_start_o,
  output logic [8:0] eye_width_o,
  output logic [8:0] cur_phase_o
);
  localparam int CMAX = (TIMEOUT > WINDOW) ? ((TIMEOUT > SETTLE) ? TIMEOUT : SETTLE)
                                           : ((WINDOW > SETTLE) ? WINDOW : SETTLE);
  localparam int CW = $clog2(CMAX + 1);
  typedef enum logic [3:0] {
    S_IDLE, S_RST, S_RWAIT, S_SETTLE, S_MEAS, S_STEP, S_SWAIT, S_CALC, S_CTR, S_CWAIT, S_DONE, S_FAIL
  } state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8:0]    err_cnt_q, err_cnt_d, run_q, run_d, cur_q, cur_d;
  logic [8:0]    eye_start_q, eye_start_d, eye_width_q, eye_width_d, target_q, target_d;
  logic [8:0]    run_inc;
  logic          busy, wait_ok, wait_to, good;
  assign busy    = !(state_q inside {S_IDLE, S_DONE, S_FAIL});
  assign wait_ok = (cnt_q >= CW'(2)) && dcm_done_i && dcm_locked_i;
  assign wait_to = cnt_q == CW'(TIMEOUT);
  assign good    = (err_cnt_q == 9'd0) && !err_i;
  assign run_inc = run_q + 9'd1;
  // next state, command strobe and datapath updates; abort or reset suppresses any strobe
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    err_cnt_d   = err_cnt_q;
    run_d       = run_q;
    cur_d       = cur_q;
    eye_start_d = eye_start_q;
    eye_width_d = eye_width_q;
    target_d    = target_q;
    wcmd_o      = 1'b0;
    cmd_o       = 4'd0;
    if (busy && (abort_i || !rst_n_i)) state_d = S_FAIL;
    else begin
      case (state_q)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start_i && !abort_i) begin
            state_d     = S_RST;
            eye_start_d = 9'd0;
            eye_width_d = 9'd0;
            run_d       = 9'd0;
          end
        end
        S_RST: begin
          wcmd_o  = 1'b1;
          cmd_o   = 4'd3;
          cur_d   = 9'd0;
          cnt_d   = '0;
          state_d = S_RWAIT;
        end
        S_RWAIT, S_SWAIT: begin
          if (wait_ok) begin
            state_d = S_SETTLE;
            cnt_d   = '0;
          end else if (wait_to) state_d = S_FAIL;
        end
        S_CWAIT: state_d = wait_ok ? S_CTR : (wait_to ? S_FAIL : S_CWAIT);
        S_SETTLE: begin
          if (cnt_q == CW'(SETTLE - 1)) begin
            state_d   = S_MEAS;
            cnt_d     = '0;
            err_cnt_d = 9'd0;
          end
        end
        S_MEAS: begin
          err_cnt_d = (err_i && err_cnt_q != 9'h1ff) ? err_cnt_q + 9'd1 : err_cnt_q;
          if (cnt_q == CW'(WINDOW - 1)) begin
            run_d = good ? run_inc : 9'd0;
            if (good && run_inc > eye_width_q) begin
              eye_width_d = run_inc;
              eye_start_d = cur_q - run_q;
            end
            state_d = (cur_q == 9'(MAX_STEPS)) ? S_CALC : S_STEP;
          end
        end
        S_STEP: begin
          wcmd_o  = 1'b1;
          cmd_o   = 4'd1;
          cur_d   = cur_q + 9'd1;
          cnt_d   = '0;
          state_d = S_SWAIT;
        end
        S_CALC: begin
          target_d = eye_start_q + ((eye_width_q - 9'd1) >> 1);
          state_d  = (eye_width_q == 9'd0) ? S_FAIL : S_CTR;
        end
        S_CTR: begin
          if (cur_q == target_q) state_d = S_DONE;
          else begin
            wcmd_o  = 1'b1;
            cmd_o   = 4'd2;
            cur_d   = cur_q - 9'd1;
            cnt_d   = '0;
            state_d = S_CWAIT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  // state and datapath registers with synchronous active-low reset
  always_ff @(posedge cclk_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      err_cnt_q   <= 9'd0;
      run_q       <= 9'd0;
      cur_q       <= 9'd0;
      eye_start_q <= 9'd0;
      eye_width_q <= 9'd0;
      target_q    <= 9'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_cnt_q   <= err_cnt_d;
      run_q       <= run_d;
      cur_q       <= cur_d;
      eye_start_q <= eye_start_d;
      eye_width_q <= eye_width_d;
      target_q    <= target_d;
    end
  end
  assign busy_o      = busy;
  assign cal_done_o  = state_q == S_DONE;
  assign cal_fail_o  = state_q == S_FAIL;
  assign eye_start_o = eye_start_q;
  assign eye_width_o = eye_width_q;
  assign cur_phase_o = cur_q;
endmodule
